load_weight_mc: RTL and testbench

LOAD_WEIGHT_MC -- requirements
Module: load_weight_mc

---
 rtl/load_weight_pkg.sv | 26 ++
 rtl/lw_rd_pipe.sv | 59 +++++
 rtl/load_weight_mc.sv | 212 +++++++++++++++++++++
 tb/tb_load_weight_mc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_weight_pkg.sv
// Shared types and sizing helpers for the multi-channel weight loader.
// Latency: none (declarations only).
// Backpressure: not applicable.
package load_weight_pkg;

  // Deepest BRAM read latency the loader's drain counter and delay line cover.
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lw_state_e;

  // Number of weights packed in one BRAM word.
  function automatic int lw_lanes(input int bram_w, input int weight_w);
    return bram_w / weight_w;
  endfunction

  // Index width for n items; never zero so single-item cases still elaborate.
  function automatic int lw_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lw_rd_pipe.sv
// Read-return delay line carrying tap index and byte lane beside each BRAM read.
// Latency: DEPTH cycles, matched to the BRAM read latency.
// Backpressure: none; one entry may enter per cycle and reset drops all in-flight entries.
module lw_rd_pipe
  import load_weight_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int TAP_W  = 4,
  parameter int LANE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [TAP_W-1:0]  in_tap,
  input  logic [LANE_W-1:0] in_lane,
  output logic              out_vld,
  output logic [TAP_W-1:0]  out_tap,
  output logic [LANE_W-1:0] out_lane
);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [TAP_W-1:0]  tap_q  [DEPTH];
  logic [TAP_W-1:0]  tap_d  [DEPTH];
  logic [LANE_W-1:0] lane_q [DEPTH];
  logic [LANE_W-1:0] lane_d [DEPTH];

  // Shift every stage one step toward the output, new entry at stage 0.
  always_comb begin
    vld_d     = '0;
    tap_d     = '{default: '0};
    lane_d    = '{default: '0};
    vld_d[0]  = in_vld;
    tap_d[0]  = in_tap;
    lane_d[0] = in_lane;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      tap_d[i]  = tap_q[i-1];
      lane_d[i] = lane_q[i-1];
    end
  end

  // Stage registers; reset clears valids so aborted reads never land.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      tap_q  <= '{default: '0};
      lane_q <= '{default: '0};
    end else begin
      vld_q  <= vld_d;
      tap_q  <= tap_d;
      lane_q <= lane_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_tap  = tap_q[DEPTH-1];
  assign out_lane = lane_q[DEPTH-1];

endmodule

// File: rtl/load_weight_mc.sv
// Loads one KSIZE-tap kernel group per request from NUM_CH BRAM ports into a flat weight bus.
// Latency: load_start to load_end is KSIZE+RD_LAT+1 cycles; one read issued per FETCH cycle.
// Backpressure: none; load_start is ignored while busy. LOAD_WEIGHT_SHADOW_EN stages taps in shadow regs.
module load_weight_mc
  import load_weight_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int KSIZE         = 9,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int BRAM_WIDTH    = 32,
  parameter int BRAM_ADDR_BIT = 32,
  parameter int RD_LAT        = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   load_start,
  input  logic [BRAM_ADDR_BIT-1:0]               weight_size,
  output logic                                   busy,
  output logic                                   load_end,
  output logic                                   weight_end,
  output logic [NUM_CH*KSIZE*WEIGHT_WIDTH-1:0]   weights,
  output logic                                   bram_clk,
  output logic                                   bram_en,
  output logic                                   bram_rst,
  output logic [NUM_CH*BRAM_WIDTH-1:0]           bram_din,
  output logic [NUM_CH*(BRAM_WIDTH/WEIGHT_WIDTH)-1:0] bram_wen,
  output logic [BRAM_ADDR_BIT-1:0]               bram_addr,
  input  logic [NUM_CH*BRAM_WIDTH-1:0]           bram_dout
);

  localparam int LANES  = lw_lanes(BRAM_WIDTH, WEIGHT_WIDTH);
  localparam int LANE_W = lw_idx_w(LANES);
  localparam int TAP_W  = lw_idx_w(KSIZE);
  localparam int DRN_W  = lw_idx_w(RD_LAT_MAX);
  localparam logic [BRAM_ADDR_BIT-1:0] ADDR_ONE = 1;
  localparam logic [TAP_W-1:0]         TAP_LAST = TAP_W'(KSIZE - 1);
  localparam logic [DRN_W-1:0]         DRN_LAST = DRN_W'(RD_LAT - 1);

  lw_state_e                state_q, state_d;
  logic [BRAM_ADDR_BIT-1:0] addr_q, addr_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic [DRN_W-1:0]         drn_q, drn_d;
  logic                     wend_q, wend_d;
  logic [WEIGHT_WIDTH-1:0]  wgt_q [NUM_CH][KSIZE];
  logic [WEIGHT_WIDTH-1:0]  wgt_d [NUM_CH][KSIZE];
`ifdef LOAD_WEIGHT_SHADOW_EN
  logic [WEIGHT_WIDTH-1:0]  shd_q [NUM_CH][KSIZE];
  logic [WEIGHT_WIDTH-1:0]  shd_d [NUM_CH][KSIZE];
`endif

  logic                     addr_wrap;
  logic                     last_drain;
  logic [LANE_W-1:0]        lane_in;
  logic                     pipe_vld;
  logic [TAP_W-1:0]         pipe_tap;
  logic [LANE_W-1:0]        pipe_lane;
  logic [WEIGHT_WIDTH-1:0]  lane_dat [NUM_CH];

  // The current read is the last valid address; >= also recovers if weight_size shrinks.
  assign addr_wrap  = (addr_q >= weight_size - ADDR_ONE);
  assign last_drain = (state_q == DRAIN) && (drn_q == DRN_LAST);

  // Next-state logic: sequencing, read address walk and wrap flag.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tap_d   = tap_q;
    drn_d   = drn_q;
    wend_d  = wend_q;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = FETCH;
          tap_d   = '0;
          wend_d  = 1'b0;
        end
      end
      FETCH: begin
        if (addr_wrap) begin
          addr_d = '0;
          wend_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
        if (tap_q == TAP_LAST) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) state_d = DONE;
        else                   drn_d   = drn_q + 1'b1;
      end
      DONE: begin
        if (load_start) begin
          state_d = FETCH;
          tap_d   = '0;
          wend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; the address deliberately survives across groups.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tap_q   <= '0;
      drn_q   <= '0;
      wend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tap_q   <= tap_d;
      drn_q   <= drn_d;
      wend_q  <= wend_d;
    end
  end

  // Byte lane of the word being read; a one-weight word always uses lane 0.
  always_comb begin
    lane_in = '0;
    if (LANES > 1) lane_in = addr_q[LANE_W-1:0];
  end

  lw_rd_pipe #(
    .DEPTH  (RD_LAT),
    .TAP_W  (TAP_W),
    .LANE_W (LANE_W)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (state_q == FETCH),
    .in_tap   (tap_q),
    .in_lane  (lane_in),
    .out_vld  (pipe_vld),
    .out_tap  (pipe_tap),
    .out_lane (pipe_lane)
  );

  // Pick the returning weight out of each channel's BRAM word.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lane_dat[c] = '0;
      for (int l = 0; l < LANES; l++) begin
        if (pipe_lane == LANE_W'(l))
          lane_dat[c] = bram_dout[c*BRAM_WIDTH + l*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

`ifdef LOAD_WEIGHT_SHADOW_EN
  // Collect taps in the shadow set; publish it as the final tap lands so weights change once per group.
  always_comb begin
    shd_d = shd_q;
    wgt_d = wgt_q;
    if (pipe_vld) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int t = 0; t < KSIZE; t++)
          if (pipe_tap == TAP_W'(t)) shd_d[c][t] = lane_dat[c];
    end
    if (last_drain) wgt_d = shd_d;
  end

  // Shadow tap storage.
  always_ff @(posedge clk) begin
    if (rst) shd_q <= '{default: '0};
    else     shd_q <= shd_d;
  end
`else
  // Write each returning tap straight into the visible weights.
  always_comb begin
    wgt_d = wgt_q;
    if (pipe_vld) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int t = 0; t < KSIZE; t++)
          if (pipe_tap == TAP_W'(t)) wgt_d[c][t] = lane_dat[c];
    end
  end
`endif

  // Visible weight storage.
  always_ff @(posedge clk) begin
    if (rst) wgt_q <= '{default: '0};
    else     wgt_q <= wgt_d;
  end

  // Flatten: tap 0 of each channel sits at the channel's MSB end.
  always_comb begin
    weights = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int t = 0; t < KSIZE; t++)
        weights[(c*KSIZE + KSIZE - 1 - t)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wgt_q[c][t];
  end

  assign busy       = (state_q == FETCH) || (state_q == DRAIN);
  assign load_end   = (state_q == DONE);
  assign weight_end = wend_q;
  assign bram_clk   = clk;
  assign bram_en    = (state_q == FETCH);
  assign bram_addr  = addr_q;
  assign bram_rst   = 1'b0;
  assign bram_din   = '0;
  assign bram_wen   = '0;

endmodule

// File: tb/tb_load_weight_mc.sv
// Bench for load_weight_mc: a default-parameter instance and an RD_LAT=3 / NUM_CH=2 instance
// share stimulus; a reference model queues expected groups and a monitor checks each load_end.
// Tap-update visibility is checked according to LOAD_WEIGHT_SHADOW_EN.
module tb_load_weight_mc;

  localparam int K   = 9;
  localparam int W   = 8;
  localparam int NCA = 4;
  localparam int NCB = 2;
  localparam int RA  = 1;
  localparam int RB  = 3;
  localparam int WV  = NCA*K*W;
  localparam int WVB = NCB*K*W;

  typedef struct {
    int             end_cyc;
    bit             wend;
    logic [WV-1:0]  w;
    int             addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [31:0] weight_size;

  logic              a_busy, a_end, a_wend, a_bclk, a_en, a_rst;
  logic [WV-1:0]     a_w;
  logic [NCA*32-1:0] a_din, a_dout;
  logic [NCA*4-1:0]  a_wen;
  logic [31:0]       a_addr;

  logic              b_busy, b_end, b_wend, b_bclk, b_en, b_rst;
  logic [WVB-1:0]    b_w;
  logic [WV-1:0]     b_w_ext;
  logic [NCB*32-1:0] b_din, b_dout;
  logic [NCB*4-1:0]  b_wen;
  logic [31:0]       b_addr;

  assign b_w_ext = WV'(b_w);

  load_weight_mc u_dut_a (
    .clk(clk), .rst(rst), .load_start(load_start), .weight_size(weight_size),
    .busy(a_busy), .load_end(a_end), .weight_end(a_wend), .weights(a_w),
    .bram_clk(a_bclk), .bram_en(a_en), .bram_rst(a_rst), .bram_din(a_din),
    .bram_wen(a_wen), .bram_addr(a_addr), .bram_dout(a_dout)
  );

  load_weight_mc #(.NUM_CH(NCB), .RD_LAT(RB)) u_dut_b (
    .clk(clk), .rst(rst), .load_start(load_start), .weight_size(weight_size),
    .busy(b_busy), .load_end(b_end), .weight_end(b_wend), .weights(b_w),
    .bram_clk(b_bclk), .bram_en(b_en), .bram_rst(b_rst), .bram_din(b_din),
    .bram_wen(b_wen), .bram_addr(b_addr), .bram_dout(b_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM contents: channel 0 byte = its address, other channels random.
  logic [7:0] mem [NCA][64];

  function automatic logic [31:0] word_at(input int c, input int a);
    int base;
    base = a & 60;
    return {mem[c][base+3], mem[c][base+2], mem[c][base+1], mem[c][base]};
  endfunction

  // BRAM models with their own read latency.
  logic [NCA*32-1:0] a_pipe [RA];
  logic [NCB*32-1:0] b_pipe [RB];
  always @(posedge clk) begin
    for (int c = 0; c < NCA; c++)
      a_pipe[0][c*32 +: 32] <= a_en ? word_at(c, int'(a_addr[5:0])) : 32'h0;
    for (int i = 1; i < RA; i++) a_pipe[i] <= a_pipe[i-1];
    for (int c = 0; c < NCB; c++)
      b_pipe[0][c*32 +: 32] <= b_en ? word_at(c, int'(b_addr[5:0])) : 32'h0;
    for (int i = 1; i < RB; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign a_dout = a_pipe[RA-1];
  assign b_dout = b_pipe[RB-1];

  // Reference model state.
  int   m_addr  [2];
  int   next_ok [2];
  int   last_s  [2];
  logic [7:0] m_tap0;
  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [WV-1:0] act, input logic [WV-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_addr[d]  = 0;
      next_ok[d] = 0;
      last_s[d]  = -1000;
    end
    qa.delete();
    qb.delete();
  endtask

  // A request in cycle n is taken when the loader is idle or finishing; the group
  // reads K consecutive addresses wrapping at weight_size and ends K+RD_LAT+1 later.
  task automatic model_start(input int d, input int n);
    exp_t e;
    int nc, r, ws, a;
    nc = (d == 0) ? NCA : NCB;
    r  = (d == 0) ? RA : RB;
    ws = int'(weight_size);
    if (n < next_ok[d]) return;
    e.w    = '0;
    e.wend = 1'b0;
    if (d == 0) m_tap0 = mem[0][m_addr[0]];
    for (int t = 0; t < K; t++) begin
      a = m_addr[d];
      for (int c = 0; c < nc; c++) e.w[(c*K + K - 1 - t)*W +: W] = mem[c][a];
      if (a == ws - 1) begin
        m_addr[d] = 0;
        e.wend    = 1'b1;
      end else begin
        m_addr[d] = a + 1;
      end
    end
    e.end_cyc  = n + K + r + 1;
    e.addr     = m_addr[d];
    next_ok[d] = e.end_cyc;
    last_s[d]  = n;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t qfront(input int d);
    exp_t e;
    if (d == 0) e = qa[0];
    else        e = qb[0];
    return e;
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(qa.pop_front());
    else        void'(qb.pop_front());
  endtask

  // Monitor: busy every cycle, and each load_end against the queued expectation.
  task automatic mon(input int d, input logic le, input logic we, input logic [WV-1:0] w,
                     input logic [31:0] addr, input logic bz);
    exp_t  e;
    int    r;
    string tag;
    r   = (d == 0) ? RA : RB;
    tag = (d == 0) ? "a" : "b";
    check({tag, "_busy"}, WV'(bz), WV'((cyc > last_s[d]) && (cyc <= last_s[d] + K + r)));
    while (qsize(d) > 0 && qfront(d).end_cyc < cyc) begin
      e = qfront(d);
      n_cmp++;
      n_bad++;
      $display("FAIL %s_load_end_missing: got none by cycle %0d expected at cycle %0d", tag, cyc, e.end_cyc);
      qpop(d);
    end
    if (le) begin
      if (qsize(d) == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_load_end_unexpected: got pulse at cycle %0d expected none", tag, cyc);
      end else begin
        e = qfront(d);
        qpop(d);
        check({tag, "_end_cycle"}, WV'(cyc), WV'(e.end_cyc));
        check({tag, "_weight_end"}, WV'(we), WV'(e.wend));
        check({tag, "_weights"}, w, e.w);
        check({tag, "_addr_after"}, WV'(addr), WV'(e.addr));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, a_end, a_wend, a_w, a_addr, a_busy);
      mon(1, b_end, b_wend, b_w_ext, b_addr, b_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    model_start(0, cyc);
    model_start(1, cyc);
    tick();
    load_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc <= next_ok[0] || cyc <= next_ok[1]) tick();
    tick();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_a_busy"}, WV'(a_busy), '0);
    check({tag, "_a_load_end"}, WV'(a_end), '0);
    check({tag, "_a_weight_end"}, WV'(a_wend), '0);
    check({tag, "_a_weights"}, a_w, '0);
    check({tag, "_a_addr"}, WV'(a_addr), '0);
    check({tag, "_b_weights"}, b_w_ext, '0);
    check({tag, "_b_addr"}, WV'(b_addr), '0);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    load_start  = 1'b0;
    weight_size = 32'd18;
    for (int c = 0; c < NCA; c++)
      for (int a = 0; a < 64; a++)
        mem[c][a] = (c == 0) ? 8'(a) : 8'($urandom);
    model_reset();
    repeat (3) tick();
    do_reset();

    // Reset state, including the constant BRAM control outputs.
    check_cleared("reset");
    check("a_bram_rst", WV'(a_rst), '0);
    check("a_bram_din", WV'(a_din), '0);
    check("a_bram_wen", WV'(a_wen), '0);

    // First group (taps 0..8) then second group (9..17, wraps) with tap-update timing.
    pulse_start();
    wait_idle();
    begin
      logic [7:0] prev;
      prev = m_tap0;
      n = cyc;
      pulse_start();
      repeat (RA) tick();
      check("tap0_before_return", WV'(a_w[(K-1)*W +: W]), WV'(prev));
      tick();
`ifdef LOAD_WEIGHT_SHADOW_EN
      check("tap0_shadow_hold", WV'(a_w[(K-1)*W +: W]), WV'(prev));
`else
      check("tap0_direct_update", WV'(a_w[(K-1)*W +: W]), WV'(m_tap0));
`endif
      // A request while busy must be ignored by both instances.
      pulse_start();
      wait_idle();
    end

    // weight_size=12, three groups: third wraps mid-group and leaves address 3.
    do_reset();
    weight_size = 32'd12;
    repeat (3) begin
      pulse_start();
      wait_idle();
    end
    check("ws12_addr_final", WV'(a_addr), WV'(3));

    // Back-to-back request in the DONE cycle of instance a.
    do_reset();
    weight_size = 32'd18;
    pulse_start();
    repeat (K + RA) tick();
    pulse_start();
    wait_idle();

    // Reset during FETCH cycle 4 aborts the load and discards in-flight reads.
    do_reset();
    pulse_start();
    repeat (3) tick();
    do_reset();
    check_cleared("abort");
    repeat (4) tick();
    check("abort_late_a_weights", a_w, '0);
    check("abort_late_b_weights", b_w_ext, '0);
    pulse_start();
    wait_idle();

    // Random request streams over several table sizes, including size 1.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      weight_size = (seg == 0) ? 32'd1 : 32'($urandom_range(1, 40));
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 3) == 0) pulse_start();
        else                           tick();
      end
      wait_idle();
    end

    check("queue_a_drained", WV'(qa.size()), '0);
    check("queue_b_drained", WV'(qb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
